// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3
// encodings, the LSU state type and a funct3 legality helper.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam logic [2:0] MEM_F3_WORD = 3'b010;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE,
    RMW_RD,
    RMW_WR,
    RESP
  } lsu_state_e;

  function automatic logic f3_illegal(
    input logic       we,
    input logic [2:0] f3
  );
    if (we)
      return !(f3 inside {SB, SH, SW});
    else
      return !(f3 inside {LB, LH, LW, LBU, LHU});
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane alignment for the LSU (combinational).
// Ports: i_funct3/i_off select the access; i_rword is the memory
// word; i_wdata is store data; o_load is the extended load value;
// o_merge is i_rword with the addressed SB/SH lane(s) replaced.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_rword,
  input  logic [15:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  // addressed byte moved down to bit 0
  logic [15:0] w_sh;
  assign w_sh = 16'(i_rword >> {i_off, 3'b000});

  always_comb begin
    o_load = '0;
    unique case (i_funct3)
      LB:      o_load = {{24{w_sh[7]}}, w_sh[7:0]};
      LH:      o_load = {{16{w_sh[15]}}, w_sh};
      LW:      o_load = i_rword;
      LBU:     o_load = {24'h0, w_sh[7:0]};
      LHU:     o_load = {16'h0, w_sh};
      default: o_load = '0;
    endcase
  end

  always_comb begin
    o_merge = i_rword;
    if (i_funct3 == SB) begin
      unique case (i_off)
        2'd0: o_merge[7:0]   = i_wdata[7:0];
        2'd1: o_merge[15:8]  = i_wdata[7:0];
        2'd2: o_merge[23:16] = i_wdata[7:0];
        2'd3: o_merge[31:24] = i_wdata[7:0];
        default: o_merge = i_rword;
      endcase
    end else if (i_funct3 == SH) begin
      if (i_off[1])
        o_merge[31:16] = i_wdata;
      else
        o_merge[15:0] = i_wdata;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit over a word-wide data memory.
// Ports: req_* accept handshake from execute, resp_* one-cycle
// completion pulse, mem_* registered word-access memory port.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_read_data
);

  lsu_state_e  r_state, w_state_nxt;
  logic [2:0]  r_funct3, w_funct3_nxt;
  logic [1:0]  r_off, w_off_nxt;
  logic [15:0] r_wdata, w_wdata_nxt;
  logic [31:0] r_maddr, w_maddr_nxt;
  logic [31:0] r_mwdata, w_mwdata_nxt;
  logic        r_mrd, w_mrd_nxt;
  logic        r_mwr, w_mwr_nxt;
  logic        r_rvalid, w_rvalid_nxt;
  logic        r_rerr, w_rerr_nxt;
  logic [31:0] r_rdata, w_rdata_nxt;

  logic [31:0] w_idx;
  logic        w_err;
  logic [31:0] w_load;
  logic [31:0] w_merge;

  assign w_idx = {2'b00, req_addr[31:2]};

  // misalignment keys off size bits so LH/LHU and LW share checks
  assign w_err =
    f3_illegal(req_we, req_funct3) ||
    (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
    (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) ||
    (w_idx >= 32'(MEM_WORDS));

  lsu_lane_align u_align (
    .i_funct3 (r_funct3),
    .i_off    (r_off),
    .i_rword  (mem_read_data),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merge  (w_merge)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_funct3_nxt = r_funct3;
    w_off_nxt    = r_off;
    w_wdata_nxt  = r_wdata;
    w_maddr_nxt  = r_maddr;
    w_mwdata_nxt = r_mwdata;
    w_mrd_nxt    = 1'b0;
    w_mwr_nxt    = 1'b0;
    w_rvalid_nxt = 1'b0;
    w_rerr_nxt   = r_rerr;
    w_rdata_nxt  = r_rdata;
    unique case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_funct3_nxt = req_funct3;
          w_off_nxt    = req_addr[1:0];
          w_wdata_nxt  = req_wdata[15:0];
          if (w_err) begin
            w_state_nxt  = RESP;
            w_rvalid_nxt = 1'b1;
            w_rerr_nxt   = 1'b1;
            w_rdata_nxt  = '0;
          end else if (!req_we) begin
            w_state_nxt = LOAD;
            w_mrd_nxt   = 1'b1;
            w_maddr_nxt = w_idx;
          end else if (req_funct3 == SW) begin
            w_state_nxt  = STORE;
            w_mwr_nxt    = 1'b1;
            w_mwdata_nxt = req_wdata;
            w_maddr_nxt  = w_idx;
          end else begin
            w_state_nxt = RMW_RD;
            w_mrd_nxt   = 1'b1;
            w_maddr_nxt = w_idx;
          end
        end
      end
      LOAD: begin
        w_state_nxt  = RESP;
        w_rvalid_nxt = 1'b1;
        w_rerr_nxt   = 1'b0;
        w_rdata_nxt  = w_load;
      end
      RMW_RD: begin
        w_state_nxt  = RMW_WR;
        w_mwr_nxt    = 1'b1;
        w_mwdata_nxt = w_merge;
      end
      STORE, RMW_WR: begin
        w_state_nxt  = RESP;
        w_rvalid_nxt = 1'b1;
        w_rerr_nxt   = 1'b0;
        w_rdata_nxt  = '0;
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_funct3 <= '0;
      r_off    <= '0;
      r_wdata  <= '0;
      r_maddr  <= '0;
      r_mwdata <= '0;
      r_mrd    <= 1'b0;
      r_mwr    <= 1'b0;
      r_rvalid <= 1'b0;
      r_rerr   <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_funct3 <= w_funct3_nxt;
      r_off    <= w_off_nxt;
      r_wdata  <= w_wdata_nxt;
      r_maddr  <= w_maddr_nxt;
      r_mwdata <= w_mwdata_nxt;
      r_mrd    <= w_mrd_nxt;
      r_mwr    <= w_mwr_nxt;
      r_rvalid <= w_rvalid_nxt;
      r_rerr   <= w_rerr_nxt;
      r_rdata  <= w_rdata_nxt;
    end
  end

  assign req_ready      = (r_state == IDLE);
  assign resp_valid     = r_rvalid;
  assign resp_rdata     = r_rdata;
  assign resp_err       = r_rerr;
  assign mem_addr       = r_maddr;
  assign mem_write_data = r_mwdata;
  assign mem_read       = r_mrd;
  assign mem_write      = r_mwr;
  assign mem_funct3     = MEM_F3_WORD;

endmodule
